// File: rtl/trap_unit.sv
// Machine-mode trap sequencer: interrupts, exceptions, MRET and WFI sleep.
// Produces registered trap/MRET pulses, fetch redirects and a WFI stall.
package riscv_pkg;
    typedef struct packed {
        logic meip;
        logic mtip;
        logic msip;
    } interrupt_t;
endpackage

module trap_unit
    import riscv_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int HoldoffCycles = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_mstatus_mie,
    input  logic [XLEN-1:0] i_mie,
    input  interrupt_t      i_interrupts,
    input  logic [XLEN-1:0] i_mtvec,
    input  logic [XLEN-1:0] i_mepc,
    input  logic            i_instr_valid,
    input  logic [XLEN-1:0] i_instr_pc,
    input  logic            i_exception_valid,
    input  logic [XLEN-1:0] i_exception_cause,
    input  logic [XLEN-1:0] i_exception_tval,
    input  logic            i_mret,
    input  logic            i_wfi,
    output logic            o_trap_taken,
    output logic [XLEN-1:0] o_trap_pc,
    output logic [XLEN-1:0] o_trap_cause,
    output logic [XLEN-1:0] o_trap_value,
    output logic            o_mret_taken,
    output logic            o_redirect_valid,
    output logic [XLEN-1:0] o_redirect_pc,
    output logic            o_stall
);

    localparam logic [XLEN-1:0] CauseMei = {1'b1, {(XLEN-5){1'b0}}, 4'd11};
    localparam logic [XLEN-1:0] CauseMsi = {1'b1, {(XLEN-5){1'b0}}, 4'd3};
    localparam logic [XLEN-1:0] CauseMti = {1'b1, {(XLEN-5){1'b0}}, 4'd7};

    typedef enum logic [1:0] {
        IDLE,
        WFI_SLEEP,
        HOLDOFF
    } state_t;

    state_t          r_state, w_state_nx;
    logic [2:0]      r_cnt, w_cnt_nx;
    logic [XLEN-1:0] r_wake_pc, w_wake_nx;
    logic            r_trap, w_trap_nx;
    logic            r_mret, w_mret_nx;
    logic            r_stall, w_stall_nx;
    logic [XLEN-1:0] r_tpc, w_tpc_nx;
    logic [XLEN-1:0] r_tcause, w_tcause_nx;
    logic [XLEN-1:0] r_tval, w_tval_nx;
    logic [XLEN-1:0] r_rpc, w_rpc_nx;

    logic [XLEN-1:0] w_mip;
    logic [XLEN-1:0] w_vec;
    logic [XLEN-1:0] w_cause;
    logic            w_pend;
    logic            w_irq;

    always_comb begin
        w_mip     = '0;
        w_mip[11] = i_interrupts.meip;
        w_mip[7]  = i_interrupts.mtip;
        w_mip[3]  = i_interrupts.msip;
    end

    assign w_pend = |(w_mip & i_mie);
    assign w_irq  = i_mstatus_mie & w_pend;
    assign w_vec  = i_mtvec & ~XLEN'(3);

    always_comb begin
        w_cause = CauseMti;
        if (w_mip[11] && i_mie[11]) begin
            w_cause = CauseMei;
        end else if (w_mip[3] && i_mie[3]) begin
            w_cause = CauseMsi;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_wake_nx   = r_wake_pc;
        w_trap_nx   = 1'b0;
        w_mret_nx   = 1'b0;
        w_stall_nx  = r_stall;
        w_tpc_nx    = r_tpc;
        w_tcause_nx = r_tcause;
        w_tval_nx   = r_tval;
        w_rpc_nx    = r_rpc;
        unique case (r_state)
            IDLE: begin
                if (i_instr_valid) begin
                    if (w_irq) begin
                        w_trap_nx   = 1'b1;
                        w_tpc_nx    = i_instr_pc;
                        w_tcause_nx = w_cause;
                        w_tval_nx   = '0;
                        w_rpc_nx    = w_vec;
                        w_state_nx  = HOLDOFF;
                        w_cnt_nx    = 3'(HoldoffCycles);
                    end else if (i_exception_valid) begin
                        w_trap_nx   = 1'b1;
                        w_tpc_nx    = i_instr_pc;
                        w_tcause_nx = i_exception_cause;
                        w_tval_nx   = i_exception_tval;
                        w_rpc_nx    = w_vec;
                        w_state_nx  = HOLDOFF;
                        w_cnt_nx    = 3'(HoldoffCycles);
                    end else if (i_mret) begin
                        w_mret_nx  = 1'b1;
                        w_rpc_nx   = i_mepc;
                        w_state_nx = HOLDOFF;
                        w_cnt_nx   = 3'(HoldoffCycles);
                    end else if (i_wfi && !w_pend) begin
                        w_state_nx = WFI_SLEEP;
                        w_wake_nx  = i_instr_pc + XLEN'(4);
                        w_stall_nx = 1'b1;
                    end
                end
            end
            WFI_SLEEP: begin
                if (w_pend) begin
                    w_stall_nx = 1'b0;
                    w_state_nx = IDLE;
                    if (i_mstatus_mie) begin
                        w_trap_nx   = 1'b1;
                        w_tpc_nx    = r_wake_pc;
                        w_tcause_nx = w_cause;
                        w_tval_nx   = '0;
                        w_rpc_nx    = w_vec;
                        w_state_nx  = HOLDOFF;
                        w_cnt_nx    = 3'(HoldoffCycles);
                    end
                end
            end
            HOLDOFF: begin
                // counter reaches 0 on the last holdoff cycle
                if (r_cnt == 3'd0) begin
                    w_state_nx = IDLE;
                end else begin
                    w_cnt_nx = r_cnt - 3'd1;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_wake_pc <= '0;
            r_trap    <= 1'b0;
            r_mret    <= 1'b0;
            r_stall   <= 1'b0;
            r_tpc     <= '0;
            r_tcause  <= '0;
            r_tval    <= '0;
            r_rpc     <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_wake_pc <= w_wake_nx;
            r_trap    <= w_trap_nx;
            r_mret    <= w_mret_nx;
            r_stall   <= w_stall_nx;
            r_tpc     <= w_tpc_nx;
            r_tcause  <= w_tcause_nx;
            r_tval    <= w_tval_nx;
            r_rpc     <= w_rpc_nx;
        end
    end

    assign o_trap_taken     = r_trap;
    assign o_mret_taken     = r_mret;
    assign o_redirect_valid = r_trap | r_mret;
    assign o_redirect_pc    = r_rpc;
    assign o_trap_pc        = r_tpc;
    assign o_trap_cause     = r_tcause;
    assign o_trap_value     = r_tval;
    assign o_stall          = r_stall;

endmodule

// File: tb/tb_trap_unit.sv
// Scoreboard bench for trap_unit: directed scenarios then random traffic.
// A reference model queues expected pulses; a monitor pops and compares.
module tb_trap_unit;

    localparam int XLEN = 32;
    localparam int H    = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   i_rst;
    logic                   i_mstatus_mie;
    logic [XLEN-1:0]        i_mie;
    riscv_pkg::interrupt_t  irq;
    logic [XLEN-1:0]        i_mtvec;
    logic [XLEN-1:0]        i_mepc;
    logic                   i_instr_valid;
    logic [XLEN-1:0]        i_instr_pc;
    logic                   i_exc;
    logic [XLEN-1:0]        i_exc_cause;
    logic [XLEN-1:0]        i_exc_tval;
    logic                   i_mret;
    logic                   i_wfi;
    logic                   o_trap_taken;
    logic [XLEN-1:0]        o_trap_pc;
    logic [XLEN-1:0]        o_trap_cause;
    logic [XLEN-1:0]        o_trap_value;
    logic                   o_mret_taken;
    logic                   o_redirect_valid;
    logic [XLEN-1:0]        o_redirect_pc;
    logic                   o_stall;

    trap_unit #(.XLEN(XLEN), .HoldoffCycles(H)) dut (
        .i_clk            (clk),
        .i_rst            (i_rst),
        .i_mstatus_mie    (i_mstatus_mie),
        .i_mie            (i_mie),
        .i_interrupts     (irq),
        .i_mtvec          (i_mtvec),
        .i_mepc           (i_mepc),
        .i_instr_valid    (i_instr_valid),
        .i_instr_pc       (i_instr_pc),
        .i_exception_valid(i_exc),
        .i_exception_cause(i_exc_cause),
        .i_exception_tval (i_exc_tval),
        .i_mret           (i_mret),
        .i_wfi            (i_wfi),
        .o_trap_taken     (o_trap_taken),
        .o_trap_pc        (o_trap_pc),
        .o_trap_cause     (o_trap_cause),
        .o_trap_value     (o_trap_value),
        .o_mret_taken     (o_mret_taken),
        .o_redirect_valid (o_redirect_valid),
        .o_redirect_pc    (o_redirect_pc),
        .o_stall          (o_stall)
    );

    typedef struct {
        int          due;
        int          kind;
        logic [31:0] pc;
        logic [31:0] cause;
        logic [31:0] val;
        logic [31:0] rpc;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          ecyc = 0;
    int          blocked_until = 0;
    bit          sleeping = 1'b0;
    logic [31:0] wake = '0;
    bit          rst_edge = 1'b0;
    bit          exp_stall = 1'b0;
    logic [31:0] last_pc = '0;
    logic [31:0] last_cause = '0;
    logic [31:0] last_val = '0;
    logic [31:0] last_rpc = '0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got %h want %h", name, ecyc, act, exp);
        end
    endtask

    function automatic logic [31:0] pending();
        logic [31:0] m;
        m = (32'(irq.meip) << 11) | (32'(irq.mtip) << 7) | (32'(irq.msip) << 3);
        return m & i_mie;
    endfunction

    function automatic logic [31:0] irq_cause();
        logic [31:0] p;
        p = pending();
        if (p[11]) return 32'h8000000B;
        if (p[3]) return 32'h80000003;
        return 32'h80000007;
    endfunction

    task automatic push_trap(logic [31:0] pc, logic [31:0] c, logic [31:0] v);
        exp_t e;
        e.due = ecyc + 1;
        e.kind = 1;
        e.pc = pc;
        e.cause = c;
        e.val = v;
        e.rpc = i_mtvec & ~32'd3;
        sb.push_back(e);
        blocked_until = ecyc + H + 2;
    endtask

    task automatic push_mret();
        exp_t e;
        e.due = ecyc + 1;
        e.kind = 2;
        e.pc = '0;
        e.cause = '0;
        e.val = '0;
        e.rpc = i_mepc;
        sb.push_back(e);
        blocked_until = ecyc + H + 2;
    endtask

    // Model decides what the coming edge must produce, then clocks once.
    task automatic tick();
        logic [31:0] p;
        p = pending();
        rst_edge = i_rst;
        if (i_rst) begin
            sleeping = 1'b0;
            blocked_until = 0;
            sb.delete();
        end else if (sleeping) begin
            if (p != 0) begin
                sleeping = 1'b0;
                if (i_mstatus_mie) push_trap(wake, irq_cause(), '0);
            end
        end else if (ecyc >= blocked_until && i_instr_valid) begin
            if (i_mstatus_mie && p != 0) begin
                push_trap(i_instr_pc, irq_cause(), '0);
            end else if (i_exc) begin
                push_trap(i_instr_pc, i_exc_cause, i_exc_tval);
            end else if (i_mret) begin
                push_mret();
            end else if (i_wfi && p == 0) begin
                sleeping = 1'b1;
                wake = i_instr_pc + 32'd4;
            end
        end
        exp_stall = sleeping;
        @(posedge clk);
        ecyc++;
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        exp_t e;
        bit   pulse;
        #1;
        if (rst_edge) begin
            check("rst_trap", 32'(o_trap_taken), 0);
            check("rst_mret", 32'(o_mret_taken), 0);
            check("rst_redir", 32'(o_redirect_valid), 0);
            check("rst_stall", 32'(o_stall), 0);
            check("rst_tpc", o_trap_pc, 0);
            check("rst_cause", o_trap_cause, 0);
            check("rst_val", o_trap_value, 0);
            check("rst_rpc", o_redirect_pc, 0);
            last_pc = '0;
            last_cause = '0;
            last_val = '0;
            last_rpc = '0;
        end else begin
            pulse = o_trap_taken | o_mret_taken;
            check("excl", 32'(o_trap_taken & o_mret_taken), 0);
            check("redir", 32'(o_redirect_valid), 32'(pulse));
            check("stall", 32'(o_stall), 32'(exp_stall));
            if (sb.size() > 0 && sb[0].due == ecyc) begin
                e = sb.pop_front();
                check("kind", 32'({o_trap_taken, o_mret_taken}),
                      (e.kind == 1) ? 32'd2 : 32'd1);
                if (e.kind == 1) begin
                    last_pc = e.pc;
                    last_cause = e.cause;
                    last_val = e.val;
                end
                last_rpc = e.rpc;
            end else if (pulse) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse @edge %0d: got trap=%0b mret=%0b want none",
                         ecyc, o_trap_taken, o_mret_taken);
            end
            check("tpc", o_trap_pc, last_pc);
            check("cause", o_trap_cause, last_cause);
            check("val", o_trap_value, last_val);
            check("rpc", o_redirect_pc, last_rpc);
        end
    end

    task automatic idle_inputs();
        i_instr_valid = 1'b0;
        i_exc = 1'b0;
        i_mret = 1'b0;
        i_wfi = 1'b0;
        irq = '0;
    endtask

    initial begin
        i_rst = 1'b1;
        i_mstatus_mie = 1'b0;
        i_mie = '0;
        i_mtvec = '0;
        i_mepc = '0;
        i_instr_pc = '0;
        i_exc_cause = '0;
        i_exc_tval = '0;
        idle_inputs();
        tick();
        tick();
        i_rst = 1'b0;
        tick();

        // interrupt priority MEI over MTI, mtvec low bits dropped
        i_mstatus_mie = 1'b1;
        i_mie = 32'h888;
        irq.meip = 1'b1;
        irq.mtip = 1'b1;
        i_instr_pc = 32'h100;
        i_mtvec = 32'h2001;
        i_instr_valid = 1'b1;
        tick();
        idle_inputs();
        repeat (4) tick();

        // exception, then repeated requests inside holdoff are ignored
        i_instr_valid = 1'b1;
        i_exc = 1'b1;
        i_exc_cause = 32'd2;
        i_exc_tval = 32'hDEAD;
        i_instr_pc = 32'h40;
        repeat (3) tick();
        idle_inputs();
        repeat (3) tick();

        // MRET
        i_mepc = 32'h300;
        i_instr_valid = 1'b1;
        i_mret = 1'b1;
        tick();
        idle_inputs();
        repeat (4) tick();

        // WFI sleep, woken by timer with MIE=1
        i_mie = 32'h80;
        i_instr_pc = 32'h200;
        i_instr_valid = 1'b1;
        i_wfi = 1'b1;
        tick();
        i_wfi = 1'b0;
        i_mret = 1'b1;
        repeat (10) tick();
        idle_inputs();
        irq.mtip = 1'b1;
        tick();
        idle_inputs();
        repeat (4) tick();

        // WFI sleep, woken by software irq with MIE=0: no trap
        i_mstatus_mie = 1'b0;
        i_mie = 32'h8;
        i_instr_pc = 32'h500;
        i_instr_valid = 1'b1;
        i_wfi = 1'b1;
        tick();
        idle_inputs();
        repeat (3) tick();
        irq.msip = 1'b1;
        tick();
        tick();
        idle_inputs();
        tick();

        // reset while asleep, then IDLE accepts immediately
        i_instr_valid = 1'b1;
        i_wfi = 1'b1;
        tick();
        idle_inputs();
        tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        i_instr_valid = 1'b1;
        i_mret = 1'b1;
        i_mepc = 32'h1234;
        tick();
        idle_inputs();
        repeat (4) tick();

        for (int i = 0; i < 600; i++) begin
            logic [31:0] m;
            m = $urandom_range(0, 4);
            i_rst = ($urandom_range(0, 79) == 0);
            i_mstatus_mie = ($urandom_range(0, 2) != 0);
            i_mie = (m == 0) ? 32'h0 : (m == 1) ? 32'h8 :
                    (m == 2) ? 32'h80 : (m == 3) ? 32'h800 : 32'h888;
            irq.meip = ($urandom_range(0, 9) == 0);
            irq.mtip = ($urandom_range(0, 9) == 0);
            irq.msip = ($urandom_range(0, 9) == 0);
            i_mtvec = $urandom;
            i_mepc = $urandom;
            i_instr_valid = ($urandom_range(0, 3) != 0);
            i_instr_pc = $urandom & ~32'd3;
            i_exc = ($urandom_range(0, 4) == 0);
            i_exc_cause = $urandom_range(0, 15);
            i_exc_tval = $urandom;
            i_mret = ($urandom_range(0, 5) == 0);
            i_wfi = ($urandom_range(0, 3) == 0);
            if (i_mie == 32'h0 && sleeping) i_mie = 32'h888;
            tick();
        end

        i_rst = 1'b0;
        idle_inputs();
        i_mie = 32'h888;
        irq.mtip = 1'b1;
        repeat (3) tick();
        idle_inputs();
        repeat (5) tick();
        check("sb_empty", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
